conv_mac_unit: RTL
==================

CONV_MAC_UNIT -- requirements
Module: conv_mac_unit

Interface
REQ-001 Parameter N, default 25, number of kernel taps and window pixels (5x5, raster order).
REQ-002 Parameter FRACTIONAL_BITS, default 8, fractional bits of each kernel coefficient.
REQ-003 Parameter PIX_W, default 8, unsigned pixel width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_window  input  N x PIX_W  unsigned pixel window, index 12 is the centre pixel.
REQ-007 in_kernel  input  N x 32  signed fixed-point coefficients, FRACTIONAL_BITS fraction bits.
REQ-008 in_valid  input  1  window and kernel presented.
REQ-009 in_ready  output  1  block can accept a job.
REQ-010 out_pixel  output  PIX_W  convolved, scaled, clamped pixel.
REQ-011 out_valid  output  1  out_pixel valid.
REQ-012 out_ready  input  1  consumer accepts out_pixel.

Function
REQ-013 FSM states: IDLE, ACC, DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE.
REQ-015 Accept on in_valid && in_ready: latch all N pixels and N coefficients, clear accumulator and tap counter, enter ACC.
REQ-016 Inputs SHALL be ignored outside IDLE; latched copies alone drive computation.
REQ-017 ACC: one tap per cycle, acc += signed(latched_pix[t]) * latched_kernel[t], t = 0..N-1.
REQ-018 Accumulator SHALL be 48-bit signed; pixel zero-extended before multiply; no intermediate overflow permitted.
REQ-019 After tap N-1 is accumulated, the next state is DONE.
REQ-020 Result = acc arithmetic-shifted right by FRACTIONAL_BITS, truncating toward negative infinity.
REQ-021 Shifted result > 2^PIX_W-1 SHALL saturate to 2^PIX_W-1.
REQ-022 Negative shifted result handling SHALL follow REQ-031/REQ-032.
REQ-023 DONE: out_valid = 1 and out_pixel registered; both held stable until out_ready = 1.
REQ-024 On out_valid && out_ready: next state IDLE, out_valid = 0; out_pixel keeps its last value.
REQ-025 Latency: accept edge at cycle T -> out_valid first high at cycle T+N+1 (T+26 for N=25).
REQ-026 Throughput: one result per N+2 cycles with out_ready tied high.
REQ-027 out_ready while out_valid = 0 SHALL have no effect.

Reset
REQ-028 On reset: state IDLE, out_valid 0, out_pixel 0, accumulator 0, tap counter 0, in_ready 1 in the following cycle.
REQ-029 Reset in ACC or DONE SHALL abandon the job with no result emitted; reset overrides a simultaneous in_valid.

Configuration
REQ-030 Macro CONV_ABS_EN selects negative-result handling.
REQ-031 CONV_ABS_EN defined: a negative shifted result is replaced by its magnitude, then REQ-021 applies (edge-magnitude output).
REQ-032 CONV_ABS_EN undefined: a negative shifted result clamps to 0.

Structure
REQ-033 Package conv_pkg SHALL hold KW = 32, ACC_W = 48, the FSM state enum, and default N/PIX_W/FRACTIONAL_BITS constants.
REQ-034 Sub-module conv_saturate: combinational shift, abs/clamp, saturation of the accumulator to PIX_W; contains the CONV_ABS_EN switch.

Verification
REQ-035 Identity: kernel tap12 = 256, others 0, FB = 8, all pixels 100, centre 77 -> out_pixel 77, out_valid at T+26.
REQ-036 Blur: all taps = 10, all pixels 255 -> acc 63750 -> out_pixel 249.
REQ-037 Negative: tap12 = -256, centre 50 -> out_pixel 0 without CONV_ABS_EN; 50 with it.
REQ-038 Saturation: tap12 = 1024, centre 100 -> out_pixel 255.
REQ-039 Backpressure: out_ready low 10 cycles in DONE -> out_valid/out_pixel stable, in_ready 0; out_ready high -> in_ready 1 next cycle, a new job is accepted.
REQ-040 Reset at tap 10 -> next cycle out_valid 0, in_ready 1; no stale result emitted; the next identity job returns the correct value.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared constants and types for the 5x5 convolution MAC unit.
//   KW      : kernel coefficient width (signed fixed point)
//   ACC_W   : accumulator width (signed)
//   state_t : control FSM states
//   *_DEF   : default values for the top-level parameters
package conv_pkg;

  localparam int KW      = 32;
  localparam int ACC_W   = 48;
  localparam int N_DEF   = 25;
  localparam int PIX_W_DEF = 8;
  localparam int FB_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_saturate.sv
// conv_saturate -- converts a fixed-point accumulator into an output pixel.
//   acc   in  ACC_W  signed accumulator (two's complement bit pattern)
//   pixel out PIX_W  unsigned pixel, clamped to [0, 2^PIX_W-1]
// The accumulator is arithmetic-shifted right by FRACTIONAL_BITS (floor).
// Negative results clamp to 0 by default; with macro CONV_ABS_EN defined they
// are replaced by their magnitude (edge-magnitude output) before saturation.
module conv_saturate
  import conv_pkg::*;
#(
  parameter int PIX_W           = PIX_W_DEF,
  parameter int FRACTIONAL_BITS = FB_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [PIX_W-1:0] pixel
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'd1 << PIX_W) - 64'd1);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] mag;

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
    logic [PIX_W-1:0] r;
    if (v > MAX_V)
      r = MAX_V[PIX_W-1:0];
    else if (v < 0)
      r = '0;
    else
      r = v[PIX_W-1:0];
    return r;
  endfunction

  always_comb begin
    shifted = $signed(acc) >>> FRACTIONAL_BITS;
`ifdef CONV_ABS_EN
    // Shifted value is far from the most negative ACC_W value, so negation
    // cannot overflow.
    mag = shifted[ACC_W-1] ? -shifted : shifted;
`else
    mag = shifted;
`endif
    pixel = clamp_pix(mag);
  end

endmodule

// File: rtl/conv_mac_unit.sv
// conv_mac_unit -- sequential N-tap convolution MAC, one tap per clock.
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_window  in   N x PIX_W unsigned pixels, pixel i at [i*PIX_W +: PIX_W]
//   in_kernel  in   N x 32 signed coefficients, tap i at [i*32 +: 32]
//   in_valid   in   job presented
//   in_ready   out  high in IDLE only
//   out_pixel  out  shifted/clamped result, held until the next result
//   out_valid  out  high in DONE until out_ready
//   out_ready  in   consumer accepts out_pixel
// Optional macro CONV_ABS_EN (inside conv_saturate): negative results output
// their magnitude instead of clamping to 0.
module conv_mac_unit
  import conv_pkg::*;
#(
  parameter int N               = N_DEF,
  parameter int FRACTIONAL_BITS = FB_DEF,
  parameter int PIX_W           = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*PIX_W-1:0]   in_window,
  input  logic [N*KW-1:0]      in_kernel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PIX_W-1:0]     out_pixel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int TAP_W = $clog2(N + 1);

  state_t state_q, state_d;

  logic        [PIX_W-1:0] pix_p0  [N];
  logic signed [KW-1:0]    coef_p0 [N];
  logic        [TAP_W-1:0] tap_q;
  logic signed [ACC_W-1:0] acc_p1;

  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] coef_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_next;
  logic        [PIX_W-1:0] sat_pix;
  logic                    accept;
  logic                    last_tap;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign last_tap = (tap_q == TAP_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_ACC;
      ST_ACC:  if (last_tap)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Stage p0: job capture; only these copies feed the datapath.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        pix_p0[i]  <= in_window[i*PIX_W +: PIX_W];
        coef_p0[i] <= in_kernel[i*KW +: KW];
      end
    end
  end

  // Pixel zero-extended so it stays non-negative in the signed product.
  always_comb begin
    pix_ext  = $signed(ACC_W'(pix_p0[tap_q]));
    coef_ext = ACC_W'(coef_p0[tap_q]);
    prod     = pix_ext * coef_ext;
    acc_next = acc_p1 + prod;
  end

  // The final tap's sum is scaled in the same cycle it is accumulated, so
  // out_pixel is ready as DONE is entered.
  conv_saturate #(
    .PIX_W          (PIX_W),
    .FRACTIONAL_BITS(FRACTIONAL_BITS)
  ) u_sat (
    .acc  (acc_next),
    .pixel(sat_pix)
  );

  // Stage p1: accumulation, one tap per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1    <= '0;
      tap_q     <= '0;
      out_pixel <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            acc_p1 <= '0;
            tap_q  <= '0;
          end
        end
        ST_ACC: begin
          acc_p1 <= acc_next;
          tap_q  <= tap_q + 1'b1;
          if (last_tap)
            out_pixel <= sat_pix;
        end
        default: ;
      endcase
    end
  end

endmodule
